// File: rtl/cnn_kernel_mc_pkg.sv
// cnn_kernel_mc_pkg
//   Shared defaults for the multi-channel kernel MAC: kernel geometry and
//   data widths, plus a width helper used for small counters.
package cnn_kernel_mc_pkg;

    localparam int DEF_KX     = 5;
    localparam int DEF_KY     = 5;
    localparam int DEF_I_F_BW = 8;
    localparam int DEF_W_BW   = 8;
    localparam int DEF_B_BW   = 16;
    localparam int DEF_O_BW   = 16;

    // Counter width that stays at least 1 bit when only one state is needed.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_kernel_mc_tree.sv
// cnn_kernel_mc_tree
//   S1: KX*KY parallel multiplies (unsigned fmap x signed weight), registered.
//   S2: adder tree over the products, sign-extended to ACC_BW, registered.
//   A valid/first/last/bias sideband follows the data through both stages.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   i_clear               kills both stage valids
//   i_valid/first/last    accepted beat and its group tags
//   i_bias                bias travelling with the beat
//   i_fmap, i_weight      window and weights, element n at [n*BW +: BW]
//   o_valid/first/last    sideband after S2
//   o_bias                bias after S2
//   o_sum                 registered window sum (ACC_BW, signed)
module cnn_kernel_mc_tree
    import cnn_kernel_mc_pkg::*;
#(
    parameter int KX     = DEF_KX,
    parameter int KY     = DEF_KY,
    parameter int I_F_BW = DEF_I_F_BW,
    parameter int W_BW   = DEF_W_BW,
    parameter int B_BW   = DEF_B_BW,
    parameter int ACC_BW = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_clear,
    input  logic                     i_valid,
    input  logic                     i_first,
    input  logic                     i_last,
    input  logic [B_BW-1:0]          i_bias,
    input  logic [KX*KY*I_F_BW-1:0]  i_fmap,
    input  logic [KX*KY*W_BW-1:0]    i_weight,
    output logic                     o_valid,
    output logic                     o_first,
    output logic                     o_last,
    output logic [B_BW-1:0]          o_bias,
    output logic [ACC_BW-1:0]        o_sum
);

    localparam int NTAP    = KX * KY;
    localparam int PROD_BW = I_F_BW + W_BW + 1;

    logic [PROD_BW-1:0] w_prod [NTAP];
    logic [PROD_BW-1:0] r_prod [NTAP];
    logic [ACC_BW-1:0]  w_sum;
    logic               r_v1, r_f1, r_l1, r_v2, r_f2, r_l2;
    logic [B_BW-1:0]    r_b1, r_b2;
    logic [ACC_BW-1:0]  r_sum;

    // Both operands extended to the product width; the low PROD_BW bits of
    // the product are the exact signed result.
    always_comb begin
        for (int n = 0; n < NTAP; n++) begin
            w_prod[n] = {{W_BW{1'b0}}, i_fmap[n*I_F_BW +: I_F_BW]}
                      * {{(I_F_BW+1){i_weight[n*W_BW + W_BW-1]}}, i_weight[n*W_BW +: W_BW]};
        end
    end

    always_comb begin
        w_sum = '0;
        for (int n = 0; n < NTAP; n++) begin
            w_sum = w_sum + {{(ACC_BW-PROD_BW){r_prod[n][PROD_BW-1]}}, r_prod[n]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < NTAP; n++) r_prod[n] <= '0;
            r_v1  <= 1'b0;
            r_f1  <= 1'b0;
            r_l1  <= 1'b0;
            r_b1  <= '0;
            r_v2  <= 1'b0;
            r_f2  <= 1'b0;
            r_l2  <= 1'b0;
            r_b2  <= '0;
            r_sum <= '0;
        end else begin
            for (int n = 0; n < NTAP; n++) r_prod[n] <= w_prod[n];
            r_v1  <= i_valid & ~i_clear;
            r_f1  <= i_first;
            r_l1  <= i_last;
            r_b1  <= i_bias;
            r_v2  <= r_v1 & ~i_clear;
            r_f2  <= r_f1;
            r_l2  <= r_l1;
            r_b2  <= r_b1;
            r_sum <= w_sum;
        end
    end

    assign o_valid = r_v2;
    assign o_first = r_f2;
    assign o_last  = r_l2;
    assign o_bias  = r_b2;
    assign o_sum   = r_sum;

endmodule

// File: rtl/cnn_kernel_mc.sv
// cnn_kernel_mc
//   Accumulates IN_CH window beats (one per input channel) into one output
//   pixel, adds a per-filter bias, then optional ReLU and saturation.
//   Beat-to-pulse latency is 4 registered stages.
// Ports:
//   clk, reset_n    clock, async active-low reset
//   i_clear         synchronous abort of the open group and in-flight beats
//   i_in_valid      beat valid
//   i_in_fmap       KX*KY unsigned fmap elements
//   i_cnn_weight    KX*KY signed weights
//   i_bias          signed bias, used only on the first beat of a group
//   o_ot_valid      one-cycle pulse per completed pixel
//   o_ot_acc        signed result, held until the next pulse
//   o_grp_open      high while a group is partially accepted
module cnn_kernel_mc
    import cnn_kernel_mc_pkg::*;
#(
    parameter int KX      = DEF_KX,
    parameter int KY      = DEF_KY,
    parameter int IN_CH   = 3,
    parameter int I_F_BW  = DEF_I_F_BW,
    parameter int W_BW    = DEF_W_BW,
    parameter int B_BW    = DEF_B_BW,
    parameter int O_BW    = DEF_O_BW,
    parameter bit RELU_EN = 1'b1,
    parameter bit SAT_EN  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_clear,
    input  logic                     i_in_valid,
    input  logic [KX*KY*I_F_BW-1:0]  i_in_fmap,
    input  logic [KX*KY*W_BW-1:0]    i_cnn_weight,
    input  logic [B_BW-1:0]          i_bias,
    output logic                     o_ot_valid,
    output logic [O_BW-1:0]          o_ot_acc,
    output logic                     o_grp_open
);

    localparam int ACC_BW = I_F_BW + 1 + W_BW + $clog2(KX*KY) + $clog2(IN_CH) + 1;
    localparam int CH_W   = cnt_width(IN_CH);

    logic [CH_W-1:0]   r_ch_cnt, w_ch_cnt_nxt;
    logic              r_grp_open;
    logic              w_first, w_last;
    logic              w_t_valid, w_t_first, w_t_last;
    logic [B_BW-1:0]   w_t_bias;
    logic [ACC_BW-1:0] w_t_sum, w_bias_ext;
    logic [ACC_BW-1:0] r_acc, w_relu;
    logic              r_acc_vld, r_acc_last;
    logic              w_in_range;
    logic [O_BW-1:0]   w_post;
    logic              r_ot_valid;
    logic [O_BW-1:0]   r_ot_acc;

    assign w_first = (r_ch_cnt == '0);
    assign w_last  = (r_ch_cnt == CH_W'(IN_CH - 1));

    always_comb begin
        w_ch_cnt_nxt = r_ch_cnt;
        if (i_clear) begin
            w_ch_cnt_nxt = '0;
        end else if (i_in_valid) begin
            w_ch_cnt_nxt = w_last ? '0 : r_ch_cnt + 1'b1;
        end
    end

    cnn_kernel_mc_tree #(
        .KX     (KX),
        .KY     (KY),
        .I_F_BW (I_F_BW),
        .W_BW   (W_BW),
        .B_BW   (B_BW),
        .ACC_BW (ACC_BW)
    ) u_tree (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (i_clear),
        .i_valid  (i_in_valid),
        .i_first  (w_first),
        .i_last   (w_last),
        .i_bias   (i_bias),
        .i_fmap   (i_in_fmap),
        .i_weight (i_cnn_weight),
        .o_valid  (w_t_valid),
        .o_first  (w_t_first),
        .o_last   (w_t_last),
        .o_bias   (w_t_bias),
        .o_sum    (w_t_sum)
    );

    assign w_bias_ext = {{(ACC_BW-B_BW){w_t_bias[B_BW-1]}}, w_t_bias};

    // S4 post-processing: ReLU first, then saturate or wrap to O_BW.
    always_comb begin
        w_relu = (RELU_EN && r_acc[ACC_BW-1]) ? '0 : r_acc;
        // Representable in O_BW iff all bits from the O_BW sign bit upward agree.
        w_in_range = (&w_relu[ACC_BW-1:O_BW-1]) | ~(|w_relu[ACC_BW-1:O_BW-1]);
        w_post = w_relu[O_BW-1:0];
        if (SAT_EN && !w_in_range) begin
            w_post = w_relu[ACC_BW-1] ? {1'b1, {(O_BW-1){1'b0}}} : {1'b0, {(O_BW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ch_cnt   <= '0;
            r_grp_open <= 1'b0;
            r_acc      <= '0;
            r_acc_vld  <= 1'b0;
            r_acc_last <= 1'b0;
            r_ot_valid <= 1'b0;
            r_ot_acc   <= '0;
        end else begin
            r_ch_cnt   <= w_ch_cnt_nxt;
            r_grp_open <= (w_ch_cnt_nxt != '0);
            r_acc_vld  <= w_t_valid & ~i_clear;
            r_acc_last <= w_t_last;
            r_ot_valid <= r_acc_vld & r_acc_last & ~i_clear;
            // First beat reloads, so nothing carries over between groups.
            if (w_t_valid) begin
                r_acc <= w_t_first ? (w_t_sum + w_bias_ext) : (r_acc + w_t_sum);
            end
            if (r_acc_vld && r_acc_last && !i_clear) begin
                r_ot_acc <= w_post;
            end
        end
    end

    assign o_ot_valid = r_ot_valid;
    assign o_ot_acc   = r_ot_acc;
    assign o_grp_open = r_grp_open;

endmodule

// File: tb/tb_cnn_kernel_mc.sv
// tb_cnn_kernel_mc
//   Directed bench for cnn_kernel_mc. Three instances share the stimulus:
//   A = ReLU on, saturate; B = ReLU off, saturate; C = ReLU off, wrap.
module tb_cnn_kernel_mc;

    localparam int NTAP = 25;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  i_clear;
    logic                  i_in_valid;
    logic [NTAP*8-1:0]     i_in_fmap;
    logic [NTAP*8-1:0]     i_cnn_weight;
    logic [15:0]           i_bias;
    logic                  vld_a, vld_b, vld_c;
    logic [15:0]           acc_a, acc_b, acc_c;
    logic                  open_a, open_b, open_c;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    cnn_kernel_mc #(.RELU_EN(1'b1), .SAT_EN(1'b1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_in_valid(i_in_valid),
        .i_in_fmap(i_in_fmap), .i_cnn_weight(i_cnn_weight), .i_bias(i_bias),
        .o_ot_valid(vld_a), .o_ot_acc(acc_a), .o_grp_open(open_a)
    );
    cnn_kernel_mc #(.RELU_EN(1'b0), .SAT_EN(1'b1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_in_valid(i_in_valid),
        .i_in_fmap(i_in_fmap), .i_cnn_weight(i_cnn_weight), .i_bias(i_bias),
        .o_ot_valid(vld_b), .o_ot_acc(acc_b), .o_grp_open(open_b)
    );
    cnn_kernel_mc #(.RELU_EN(1'b0), .SAT_EN(1'b0)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_in_valid(i_in_valid),
        .i_in_fmap(i_in_fmap), .i_cnn_weight(i_cnn_weight), .i_bias(i_bias),
        .o_ot_valid(vld_c), .o_ot_acc(acc_c), .o_grp_open(open_c)
    );

    // Pulse-cycles of instance A, sampled mid-cycle.
    always @(negedge clk) if (vld_a) pulse_cnt <= pulse_cnt + 1;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic beat(input logic [7:0] f, input logic [7:0] w, input logic [15:0] b);
        @(negedge clk);
        i_in_valid   = 1'b1;
        i_in_fmap    = {NTAP{f}};
        i_cnn_weight = {NTAP{w}};
        i_bias       = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_in_valid = 1'b0;
            i_clear    = 1'b0;
        end
    endtask

    // Wait (bounded) for a pulse after the last beat; returns cycles waited.
    task automatic wait_pulse(input string tag);
        int lat;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            idle(1);
            if (vld_a) begin
                lat = k;
                break;
            end
        end
        check_eq(tag, lat, 4);
    endtask

    task automatic group(input logic [7:0] f, input logic [7:0] w, input logic [15:0] b);
        for (int i = 0; i < 3; i++) beat(f, w, b);
    endtask

    int p0;

    initial begin
        reset_n = 1'b0;
        i_clear = 1'b0;
        i_in_valid = 1'b0;
        i_in_fmap = '0;
        i_cnn_weight = '0;
        i_bias = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", int'(vld_a), 0);
        check_eq("rst_acc", int'(acc_a), 0);
        check_eq("rst_open", int'(open_a), 0);
        reset_n = 1'b1;
        idle(2);

        // All ones: 25 * 3 = 75
        p0 = pulse_cnt;
        group(8'd1, 8'd1, 16'd0);
        wait_pulse("ones_lat");
        check_eq("ones_acc", int'($signed(acc_a)), 75);
        idle(3);
        check_eq("ones_pulses", pulse_cnt - p0, 1);

        // Negative sum: 255 * -1 * 75
        group(8'd255, 8'hFF, 16'd0);
        wait_pulse("neg_lat");
        check_eq("neg_relu", int'($signed(acc_a)), 0);
        check_eq("neg_norelu", int'($signed(acc_b)), -19125);
        check_eq("neg_wrap", int'($signed(acc_c)), -19125);
        idle(2);

        // Large positive: 255 * 127 * 75 = 2428875
        group(8'd255, 8'd127, 16'd0);
        wait_pulse("sat_lat");
        check_eq("sat_a", int'($signed(acc_a)), 32767);
        check_eq("sat_b", int'($signed(acc_b)), 32767);
        check_eq("wrap_c", int'($signed(acc_c)), 4043);
        idle(2);

        // Large negative saturates to the minimum
        group(8'd255, 8'h80, 16'd0);
        wait_pulse("negsat_lat");
        check_eq("negsat_b", int'($signed(acc_b)), -32768);
        idle(2);

        // Gaps and bias: 2*3*75 + 100; later biases must be ignored
        beat(8'd2, 8'd3, 16'd100);
        idle(1);
        check_eq("gap_open1", int'(open_a), 1);
        idle(1);
        beat(8'd2, 8'd3, 16'd999);
        idle(1);
        check_eq("gap_open2", int'(open_a), 1);
        idle(1);
        beat(8'd2, 8'd3, 16'hFFF9);
        wait_pulse("gap_lat");
        check_eq("gap_acc", int'($signed(acc_a)), 550);
        check_eq("gap_open0", int'(open_a), 0);
        idle(2);

        // Abort after 2 beats; clear also drops a coincident beat
        p0 = pulse_cnt;
        beat(8'd1, 8'd1, 16'd0);
        beat(8'd1, 8'd1, 16'd0);
        @(negedge clk);
        i_in_valid = 1'b1;
        i_clear    = 1'b1;
        idle(1);
        check_eq("abort_open", int'(open_a), 0);
        group(8'd1, 8'd1, 16'd5);
        wait_pulse("abort_lat");
        check_eq("abort_acc", int'($signed(acc_a)), 80);
        idle(3);
        check_eq("abort_pulses", pulse_cnt - p0, 1);

        // Clear right after a last beat kills it in flight
        p0 = pulse_cnt;
        group(8'd1, 8'd1, 16'd0);
        @(negedge clk);
        i_in_valid = 1'b0;
        i_clear    = 1'b1;
        idle(8);
        check_eq("kill_pulses", pulse_cnt - p0, 0);
        check_eq("kill_hold", int'($signed(acc_a)), 80);

        // Reset mid-group
        beat(8'd1, 8'd1, 16'd0);
        idle(1);
        check_eq("mid_open", int'(open_a), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mrst_acc", int'(acc_a), 0);
        check_eq("mrst_open", int'(open_a), 0);
        check_eq("mrst_valid", int'(vld_a), 0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        group(8'd1, 8'd1, 16'd0);
        wait_pulse("post_rst_lat");
        check_eq("post_rst_acc", int'($signed(acc_a)), 75);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
